// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the RV32I core.
// Sequences fetch/decode/execute/memory/writeback over a shared datapath
// with one memory port, one ALU and IR/OldPC/ALUOut/Data registers.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   Op/Funct3/Funct7b5  instruction fields from IR
//   Zero             ALU zero flag (same cycle)
//   MemReady         memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite   datapath controls
//   IllegalInstr     sticky illegal-opcode flag
//
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to send unknown opcodes to
// an absorbing TRAP state (IllegalInstr=1). Without it they act as NOPs.

module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       IllegalInstr
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_JALRPC   = 4'd12;
    localparam logic [3:0] S_UEXEC    = 4'd13;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd14;
`endif

    localparam logic [3:0] RESET_STATE = S_FETCH;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    logic [3:0] state_q, state_d;
    logic [3:0] out_state;

    // Funct7b5 selects sub only for register ops; sra for both forms.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3,
                                           input logic f7,
                                           input logic is_r);
        logic [3:0] r;
        unique case (f3)
            3'b000:  r = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  r = 4'b0111;
            3'b010:  r = 4'b0101;
            3'b011:  r = 4'b0110;
            3'b100:  r = 4'b0100;
            3'b101:  r = f7 ? 4'b1001 : 4'b1000;
            3'b110:  r = 4'b0011;
            default: r = 4'b0010;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UEXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWRITE: if (MemReady) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL,
            S_JALRPC, S_UEXEC:  state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // During reset the outputs show FETCH values with all enables held off.
    assign out_state = reset ? S_FETCH : state_q;

    always_comb begin
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUControl   = ALU_ADD;
        RegWrite     = 1'b0;
        IllegalInstr = 1'b0;
        case (out_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = MemReady;
                IRWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(Funct3, Funct7b5, 1'b1);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(Funct3, Funct7b5, 1'b0);
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = Zero ^ Funct3[0];
            end
            S_JAL, S_JALRPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_UEXEC: begin
                // lui adds the immediate to zero, auipc to OldPC
                ALUSrcA = Op[5] ? 2'b11 : 2'b01;
                ALUSrcB = 2'b01;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     IllegalInstr = 1'b1;
`endif
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (Op)
            OP_I:             if (Funct3 == 3'b001 || Funct3 == 3'b101)
                                  ImmSrc = 3'b101;
            OP_STORE:         ImmSrc = 3'b001;
            OP_BR:            ImmSrc = 3'b010;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
            OP_JAL:           ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-instruction expected control sequences checked
// every cycle, with randomized instructions, waits and Zero.

module tb_mc_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       rw;
        logic       ill;
    } ctl_t;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RT    = 7'b0110011;
    localparam logic [6:0] IT    = 7'b0010011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [3:0] ADD   = 4'b0000;
    localparam logic [3:0] SUB   = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Op = 7'd0;
    logic [2:0] Funct3 = 3'd0;
    logic       Funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0] ALUControl;
    logic [2:0] ImmSrc;

    mc_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3),
        .Funct7b5(Funct7b5), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .IllegalInstr(IllegalInstr)
    );

    always #5 clk = ~clk;

    ctl_t act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUControl, ImmSrc, RegWrite, IllegalInstr};

    int    n_checks = 0;
    int    n_fail = 0;
    ctl_t  exp_c;
    string exp_name = "";
    bit    exp_valid = 0;
    int    zf = -1;
    string lnm[$];
    ctl_t  lv[$];

    always @(negedge clk) begin
        if (exp_valid) begin
            n_checks++;
            if (act !== exp_c) begin
                n_fail++;
                $display("FAIL %s op=%b f3=%b: got %b required %b",
                         exp_name, Op, Funct3, act, exp_c);
            end
        end
    end

    function automatic ctl_t mk(logic pcw, logic adr, logic mw, logic irw,
                                logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                logic [3:0] alu, logic rw);
        ctl_t c;
        c = '0;
        c.pcw = pcw; c.adr = adr; c.mw = mw; c.irw = irw; c.rs = rs;
        c.a = a; c.b = b; c.alu = alu; c.rw = rw;
        return c;
    endfunction

    function automatic logic [2:0] imm_of(logic [6:0] op, logic [2:0] f3);
        if (op == IT) return (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
        if (op == SW) return 3'd1;
        if (op == BR) return 3'd2;
        if (op == LUI || op == AUIPC) return 3'd3;
        if (op == JAL) return 3'd4;
        return 3'd0;
    endfunction

    // Mnemonic table indexed by funct3; sub/sra picked out by funct7b5.
    function automatic logic [3:0] alu_of(logic [2:0] f3, logic f7, bit r);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (f3 == 3'd0 && r && f7) return SUB;
        if (f3 == 3'd5 && f7) return 4'd9;
        return tbl[f3];
    endfunction

    // kind: 0 plain, 1 fetch (pcw/irw follow ready), 2 branch
    task automatic step(string nm, ctl_t b, int kind, bit rdy);
        MemReady = rdy;
        Zero = (zf < 0) ? 1'($urandom) : zf[0];
        if (kind == 1) begin b.pcw = rdy; b.irw = rdy; end
        if (kind == 2) b.pcw = Zero ^ Funct3[0];
        b.imm = imm_of(Op, Funct3);
        exp_c = b;
        exp_name = nm;
        exp_valid = 1;
        @(negedge clk); #1;
        lnm.push_back(nm);
        lv.push_back(act);
        @(posedge clk); #1;
    endtask

    task automatic wait_phase(string nm, ctl_t b, int kind, int waits);
        for (int i = 0; i < waits; i++) step(nm, b, kind, 1'b0);
        step(nm, b, kind, 1'b1);
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++)
            step("RESET", mk(0, 0, 0, 0, 2'd2, 2'd0, 2'd2, ADD, 0), 0,
                 1'($urandom));
        reset = 1'b0;
    endtask

    task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic f7,
                             int fw, int mw);
        ctl_t wb;
        wb = mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, ADD, 1);
        Op = op; Funct3 = f3; Funct7b5 = f7;
        lnm.delete(); lv.delete();
        wait_phase("FETCH", mk(0, 0, 0, 0, 2'd2, 2'd0, 2'd2, ADD, 0), 1, fw);
        step("DECODE", mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, ADD, 0), 0,
             1'($urandom));
        case (op)
            LW, SW: begin
                step("MEMADR", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, ADD, 0), 0,
                     1'($urandom));
                if (op == LW) begin
                    wait_phase("MEMREAD",
                               mk(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, ADD, 0), 0, mw);
                    step("MEMWB", mk(0, 0, 0, 0, 2'd1, 2'd0, 2'd0, ADD, 1), 0,
                         1'($urandom));
                end else begin
                    wait_phase("MEMWRITE",
                               mk(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, ADD, 0), 0, mw);
                end
            end
            RT, IT: begin
                step(op == RT ? "EXECR" : "EXECI",
                     mk(0, 0, 0, 0, 2'd0, 2'd2, op == RT ? 2'd0 : 2'd1,
                        alu_of(f3, f7, op == RT), 0), 0, 1'($urandom));
                step("ALUWB", wb, 0, 1'($urandom));
            end
            BR: step("BRANCH", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, SUB, 0), 2,
                     1'($urandom));
            JAL: begin
                step("JAL", mk(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, ADD, 0), 0,
                     1'($urandom));
                step("ALUWB", wb, 0, 1'($urandom));
            end
            JALR: begin
                step("JALR", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, ADD, 0), 0,
                     1'($urandom));
                step("JALRPC", mk(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, ADD, 0), 0,
                     1'($urandom));
                step("ALUWB", wb, 0, 1'($urandom));
            end
            LUI, AUIPC: begin
                step("UEXEC", mk(0, 0, 0, 0, 2'd0, op[5] ? 2'd3 : 2'd1, 2'd1,
                                 ADD, 0), 0, 1'($urandom));
                step("ALUWB", wb, 0, 1'($urandom));
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                ctl_t t;
                t = '0;
                t.ill = 1'b1;
                for (int i = 0; i < 4; i++) step("TRAP", t, 0, 1'($urandom));
`endif
            end
        endcase
    endtask

    task automatic check_lit(string nm, logic [31:0] a, logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, a, e);
        end
    endtask

    function automatic ctl_t entry(string nm);
        foreach (lnm[i]) if (lnm[i] == nm) return lv[i];
        return 'x;
    endfunction

    function automatic int count(string nm);
        int n = 0;
        foreach (lnm[i]) if (lnm[i] == nm) n++;
        return n;
    endfunction

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op;
        ctl_t e;
        int pc_n, rw_n;
        string seq;
        ops = '{LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC};

        do_reset(2);
        run_instr(IT, 3'd0, 1'b0, 0, 0);
        check_lit("first_fetch_pcw", 32'(lv[0].pcw), 32'd1);
        check_lit("first_fetch_irw", 32'(lv[0].irw), 32'd1);

        run_instr(LW, 3'd2, 1'b0, 1, 3);
        check_lit("lw_memread_cycles", count("MEMREAD"), 32'd4);
        e = entry("MEMWB");
        check_lit("lw_memwb_rs", 32'(e.rs), 32'd1);
        check_lit("lw_memwb_rw", 32'(e.rw), 32'd1);
        check_lit("lw_imm", 32'(e.imm), 32'd0);

        for (int f = 0; f < 2; f++)
            for (int z = 0; z < 2; z++) begin
                zf = z;
                run_instr(BR, 3'(f), 1'b0, 0, 0);
                e = entry("BRANCH");
                check_lit("br_pcw", 32'(e.pcw), 32'((z == 1) ^ (f == 1)));
                check_lit("br_alu", 32'(e.alu), 32'd1);
                check_lit("br_imm", 32'(e.imm), 32'd2);
            end
        zf = -1;

        run_instr(IT, 3'd5, 1'b1, 0, 0);
        e = entry("EXECI");
        check_lit("srai_alu", 32'(e.alu), 32'd9);
        check_lit("srai_imm", 32'(e.imm), 32'd5);
        run_instr(IT, 3'd0, 1'b1, 0, 0);
        check_lit("addi_f7_alu", 32'(entry("EXECI").alu), 32'd0);

        run_instr(JALR, 3'd0, 1'b0, 0, 0);
        seq = "";
        pc_n = 0;
        rw_n = 0;
        foreach (lnm[i]) begin
            seq = {seq, lnm[i], " "};
            pc_n += int'(lv[i].pcw);
            rw_n += int'(lv[i].rw);
        end
        n_checks++;
        if (seq != "FETCH DECODE JALR JALRPC ALUWB ") begin
            n_fail++;
            $display("FAIL jalr_seq: got %s", seq);
        end
        check_lit("jalr_pcw_count", pc_n, 32'd2);
        check_lit("jalr_rw_count", rw_n, 32'd1);

        // abandon a store in MEMWRITE; the reset cycle must not strobe
        Op = SW; Funct3 = 3'd2; Funct7b5 = 1'b0;
        lnm.delete(); lv.delete();
        step("FETCH", mk(1, 0, 0, 1, 2'd2, 2'd0, 2'd2, ADD, 0), 1, 1'b1);
        step("DECODE", mk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, ADD, 0), 0, 1'b0);
        step("MEMADR", mk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, ADD, 0), 0, 1'b0);
        step("MEMWRITE", mk(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, ADD, 0), 0, 1'b0);
        do_reset(1);
        check_lit("mid_reset_mw", 32'(lv[lv.size() - 1].mw), 32'd0);

        run_instr(7'b0000000, 3'd0, 1'b0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_lit("trap_ill", 32'(entry("TRAP").ill), 32'd1);
        do_reset(1);
`else
        run_instr(RT, 3'd0, 1'b1, 0, 0);
        check_lit("illegal_nop_fetch", 32'(lv[0].irw), 32'd1);
`endif

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 8)];
`ifndef CTRL_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 9) == 0) begin
                op = 7'($urandom);
                for (int k = 0; k < 20; k++)
                    if (op inside {LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC})
                        op = 7'($urandom);
                if (op inside {LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC})
                    op = 7'b1111111;
            end
`endif
            run_instr(op, 3'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) do_reset(1);
        end

        exp_valid = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
